lutram_bist_seq: RTL and testbench

LUTRAM_BIST_SEQ -- requirements
Module: lutram_bist_seq

---
 rtl/lutram_bist_seq.sv | 144 ++++++++++++++
 tb/tb_lutram_bist_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lutram_bist_seq.sv
// rtl/lutram_bist_seq.sv - March-style write/read BIST sequencer driving a LUTRAM executor
module lutram_bist_seq #(
    parameter int INSTR_OP_WIDTH   = 2,
    parameter int INSTR_ADDR_WIDTH = 8,
    parameter int INSTR_DATA_WIDTH = 8,
    parameter int DEPTH            = 256,
    parameter logic [INSTR_DATA_WIDTH-1:0] SEED = 8'hA5
) (
    input  logic                                                       clk_i,
    input  logic                                                       rst_ni,
    input  logic                                                       start_i,
    output logic [INSTR_OP_WIDTH+INSTR_ADDR_WIDTH+INSTR_DATA_WIDTH-1:0] instr_o,
    input  logic [INSTR_DATA_WIDTH-1:0]                                lutram_do_i,
    output logic                                                       busy_o,
    output logic                                                       done_o,
    output logic                                                       pass_o,
    output logic [INSTR_ADDR_WIDTH-1:0]                                fail_addr_o,
    output logic [INSTR_DATA_WIDTH-1:0]                                fail_data_o,
    output logic [7:0]                                                 err_count_o
);
    localparam int OW = INSTR_OP_WIDTH;
    localparam int AW = INSTR_ADDR_WIDTH;
    localparam int DW = INSTR_DATA_WIDTH;
    localparam int IW = OW + AW + DW;

    localparam logic [OW-1:0] OP_WR = {OW{1'b1}};
    localparam logic [OW-1:0] OP_RD = '0;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_inc;
    logic [DW-1:0] expect_data;
    logic          last;
    logic          mismatch;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(a) ^ SEED;
    endfunction

    function automatic logic [IW-1:0] wr_instr(input logic [AW-1:0] a, input logic inv);
        return {(inv ? ~pat(a) : pat(a)), a, OP_WR};
    endfunction

    function automatic logic [IW-1:0] rd_instr(input logic [AW-1:0] a);
        return {{DW{1'b0}}, a, OP_RD};
    endfunction

    assign addr_inc    = addr + 1'b1;
    assign last        = (addr == LAST);
    assign expect_data = (state == R1) ? ~pat(addr) : pat(addr);
    assign mismatch    = ((state == R0) || (state == R1)) && (lutram_do_i != expect_data);

    // instr_o is loaded with the word for the state/address being entered,
    // so the executor always sees a registered instruction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            addr        <= '0;
            instr_o     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            err_count_o <= '0;
        end else begin
            if (mismatch) begin
                if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
                if (err_count_o == 8'd0) begin
                    fail_addr_o <= addr;
                    fail_data_o <= lutram_do_i;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= W0;
                        addr        <= '0;
                        instr_o     <= wr_instr('0, 1'b0);
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        fail_addr_o <= '0;
                        fail_data_o <= '0;
                        err_count_o <= '0;
                    end
                end
                W0: begin
                    if (last) begin
                        state   <= R0;
                        addr    <= '0;
                        instr_o <= rd_instr('0);
                    end else begin
                        addr    <= addr_inc;
                        instr_o <= wr_instr(addr_inc, 1'b0);
                    end
                end
                R0: begin
                    if (last) begin
                        state   <= W1;
                        addr    <= '0;
                        instr_o <= wr_instr('0, 1'b1);
                    end else begin
                        addr    <= addr_inc;
                        instr_o <= rd_instr(addr_inc);
                    end
                end
                W1: begin
                    if (last) begin
                        state   <= R1;
                        addr    <= '0;
                        instr_o <= rd_instr('0);
                    end else begin
                        addr    <= addr_inc;
                        instr_o <= wr_instr(addr_inc, 1'b1);
                    end
                end
                R1: begin
                    if (last) begin
                        // Final read's compare result folds into the pass verdict.
                        state   <= DONE;
                        addr    <= '0;
                        instr_o <= '0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        pass_o  <= (err_count_o == 8'd0) && !mismatch;
                    end else begin
                        addr    <= addr_inc;
                        instr_o <= rd_instr(addr_inc);
                    end
                end
                default: begin
                    state   <= IDLE;
                    addr    <= '0;
                    instr_o <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lutram_bist_seq.sv
// tb/tb_lutram_bist_seq.sv - directed self-checking bench for lutram_bist_seq
module tb_lutram_bist_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start32;
    logic [17:0] instr;
    logic [17:0] instr32;
    logic [7:0]  rdata;
    logic [7:0]  rdata32;
    logic        busy, done, pass;
    logic        busy32, done32, pass32;
    logic [7:0]  fail_addr, fail_data, err_count;
    logic [7:0]  fail_addr32, fail_data32, err_count32;

    logic [7:0]  mem   [256];
    logic [7:0]  mem32 [256];
    int          fault_mode = 0;
    int          writes = 0;
    int          bad_ops = 0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    lutram_bist_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .instr_o(instr),
        .lutram_do_i(rdata), .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_addr_o(fail_addr), .fail_data_o(fail_data), .err_count_o(err_count)
    );

    lutram_bist_seq #(.DEPTH(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .instr_o(instr32),
        .lutram_do_i(rdata32), .busy_o(busy32), .done_o(done32), .pass_o(pass32),
        .fail_addr_o(fail_addr32), .fail_data_o(fail_data32), .err_count_o(err_count32)
    );

    // LUTRAM models: write lands at the clock edge, read is combinational.
    always @(posedge clk) begin
        if (instr[1:0] == 2'b11) begin
            mem[instr[9:2]] <= instr[17:10];
            writes <= writes + 1;
        end
        if (instr[1:0] == 2'b01 || instr[1:0] == 2'b10) bad_ops <= bad_ops + 1;
        if (instr32[1:0] == 2'b11) mem32[instr32[9:2]] <= instr32[17:10];
    end

    always_comb begin
        rdata = mem[instr[9:2]];
        if (fault_mode == 1 && instr[9:2] == 8'h10) rdata = rdata & 8'hF7;
        if (fault_mode == 2) rdata = 8'h00;
        rdata32 = mem32[instr32[9:2]];
    end

    task automatic run(input int pulse_at, output int cyc, output logic [7:0] w0_data);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        w0_data = 8'hXX;
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            if (busy) cyc++;
            if (i == 16 && instr[1:0] == 2'b11 && instr[9:2] == 8'h10) w0_data = instr[17:10];
            start = (i == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        start32 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++; if (instr !== 18'h0) begin mismatched++; $display("FAIL reset_instr got %h want 0", instr); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        compared++; if (pass !== 1'b0) begin mismatched++; $display("FAIL reset_pass got %b want 0", pass); end
        compared++; if (fail_addr !== 8'h0) begin mismatched++; $display("FAIL reset_fail_addr got %h want 0", fail_addr); end
        compared++; if (fail_data !== 8'h0) begin mismatched++; $display("FAIL reset_fail_data got %h want 0", fail_data); end
        compared++; if (err_count !== 8'h0) begin mismatched++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_ideal;
        int cyc;
        logic [7:0] w0d;
        fault_mode = 0;
        run(-1, cyc, w0d);
        compared++; if (cyc !== 1024) begin mismatched++; $display("FAIL ideal_busy_cycles got %0d want 1024", cyc); end
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL ideal_done got %b want 1", done); end
        compared++; if (pass !== 1'b1) begin mismatched++; $display("FAIL ideal_pass got %b want 1", pass); end
        compared++; if (err_count !== 8'd0) begin mismatched++; $display("FAIL ideal_err_count got %0d want 0", err_count); end
        compared++; if (w0d !== 8'hB5) begin mismatched++; $display("FAIL ideal_w0_data_0x10 got %h want b5", w0d); end
        compared++; if (instr !== 18'h0) begin mismatched++; $display("FAIL done_instr got %h want 0", instr); end
    endtask

    task automatic test_start_ignored;
        int cyc;
        logic [7:0] w0d;
        run(300, cyc, w0d);
        compared++; if (cyc !== 1024) begin mismatched++; $display("FAIL ignored_start_cycles got %0d want 1024", cyc); end
        compared++; if (pass !== 1'b1) begin mismatched++; $display("FAIL ignored_start_pass got %b want 1", pass); end
    endtask

    task automatic test_stuck_bit;
        int cyc;
        logic [7:0] w0d;
        fault_mode = 1;
        run(-1, cyc, w0d);
        compared++; if (err_count !== 8'd1) begin mismatched++; $display("FAIL stuck_err_count got %0d want 1", err_count); end
        compared++; if (fail_addr !== 8'h10) begin mismatched++; $display("FAIL stuck_fail_addr got %h want 10", fail_addr); end
        compared++; if (fail_data !== 8'h42) begin mismatched++; $display("FAIL stuck_fail_data got %h want 42", fail_data); end
        compared++; if (pass !== 1'b0) begin mismatched++; $display("FAIL stuck_pass got %b want 0", pass); end
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL stuck_done got %b want 1", done); end
    endtask

    task automatic test_tied_zero;
        int cyc;
        logic [7:0] w0d;
        fault_mode = 2;
        run(-1, cyc, w0d);
        compared++; if (err_count !== 8'd255) begin mismatched++; $display("FAIL tied_err_count got %0d want 255", err_count); end
        compared++; if (fail_addr !== 8'h00) begin mismatched++; $display("FAIL tied_fail_addr got %h want 00", fail_addr); end
        compared++; if (fail_data !== 8'h00) begin mismatched++; $display("FAIL tied_fail_data got %h want 00", fail_data); end
        compared++; if (pass !== 1'b0) begin mismatched++; $display("FAIL tied_pass got %b want 0", pass); end
        fault_mode = 0;
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        int w;
        logic [7:0] w0d;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (530) @(negedge clk);
        compared++; if (instr[1:0] !== 2'b11) begin mismatched++; $display("FAIL midrun_in_w1 op got %b want 11", instr[1:0]); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if (instr !== 18'h0) begin mismatched++; $display("FAIL midrun_reset_instr got %h want 0", instr); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrun_reset_busy got %b want 0", busy); end
        w = writes;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        compared++; if (writes !== w) begin mismatched++; $display("FAIL midrun_no_write got %0d want %0d", writes, w); end
        run(-1, cyc, w0d);
        compared++; if (cyc !== 1024) begin mismatched++; $display("FAIL rerun_cycles got %0d want 1024", cyc); end
        compared++; if (pass !== 1'b1) begin mismatched++; $display("FAIL rerun_pass got %b want 1", pass); end
        compared++; if (bad_ops !== 0) begin mismatched++; $display("FAIL illegal_opcodes got %0d want 0", bad_ops); end
    endtask

    task automatic test_depth32;
        int cyc;
        int max_addr;
        cyc = 0;
        max_addr = 0;
        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done32) break;
            if (busy32) cyc++;
            if (int'(instr32[9:2]) > max_addr) max_addr = int'(instr32[9:2]);
            @(negedge clk);
        end
        compared++; if (cyc !== 128) begin mismatched++; $display("FAIL d32_busy_cycles got %0d want 128", cyc); end
        compared++; if (max_addr > 31) begin mismatched++; $display("FAIL d32_max_addr got %0d want <=31", max_addr); end
        compared++; if (pass32 !== 1'b1) begin mismatched++; $display("FAIL d32_pass got %b want 1", pass32); end
        compared++; if (done32 !== 1'b1) begin mismatched++; $display("FAIL d32_done got %b want 1", done32); end
    endtask

    initial begin
        test_reset;
        test_ideal;
        test_start_ignored;
        test_stuck_bit;
        test_tied_zero;
        test_reset_mid_run;
        test_depth32;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
